// File: rtl/svetofor_pkg.sv
// Shared codes, default register addresses and FSM state type for the
// traffic-light APB poller.
package svetofor_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam logic [3:0] DEF_CONTROL_REG_ADDR   = 4'h0;
  localparam logic [3:0] DEF_CURRENT_STATE_ADDR = 4'h4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/svetofor_apb_if.sv
// APB segment between the poller (master) and the traffic-light slave.
// Handshake: a transfer is offered from SETUP onward and completes on the
// first ACCESS rising edge where PREADY is high; address/data hold until then.
interface svetofor_apb_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/svetofor_lamp_decoder.sv
// Maps a 2-bit direction code to one-hot {R,Y,G} lamps; the unused code
// 2'b11 shows red and raises the fault bit.
module svetofor_lamp_decoder
  import svetofor_pkg::*;
(
  input  logic [1:0] code,
  output logic [2:0] lamp,
  output logic       fault
);

  always_comb begin
    lamp  = LAMP_RED;
    fault = 1'b0;
    case (code)
      RED:     lamp = LAMP_RED;
      YELLOW:  lamp = LAMP_YELLOW;
      GREEN:   lamp = LAMP_GREEN;
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/svetofor_apb_poller.sv
// APB master that periodically reads the traffic-light state register into
// lamp drives and turns skip requests into control-register writes.
module svetofor_apb_poller
  import svetofor_pkg::*;
#(
  parameter logic [3:0] CONTROL_REG_ADDR   = DEF_CONTROL_REG_ADDR,
  parameter logic [3:0] CURRENT_STATE_ADDR = DEF_CURRENT_STATE_ADDR,
  parameter int         POLL_PERIOD        = 8,
  parameter int         TIMEOUT            = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  svetofor_apb_if.master        apb,
  input  logic                  skip_req,
  output logic [2:0]            lamp1,
  output logic [2:0]            lamp2,
  output logic                  state_fault,
  output logic                  err_timeout,
  output logic                  busy,
  output apb_state_t            fsm_state
);

  localparam logic [7:0] POLL_LAST    = 8'(POLL_PERIOD - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  apb_state_t state, state_n;
  logic [7:0] poll_cnt, poll_cnt_n;
  logic [7:0] acc_cnt, acc_cnt_n;
  logic       skip_pend, skip_pend_n;
  logic       cur_write, cur_write_n;
  logic       poll_due, want_write, xfer_done, xfer_abort;
  logic [2:0] dec1, dec2;
  logic       fault1, fault2;
  logic       unused_rdata;

  assign unused_rdata = ^apb.PRDATA[31:4];

  svetofor_lamp_decoder u_dec1 (.code(apb.PRDATA[3:2]), .lamp(dec1), .fault(fault1));
  svetofor_lamp_decoder u_dec2 (.code(apb.PRDATA[1:0]), .lamp(dec2), .fault(fault2));

  always_comb begin
    state_n     = state;
    poll_cnt_n  = poll_cnt;
    acc_cnt_n   = acc_cnt;
    cur_write_n = cur_write;
    poll_due    = (poll_cnt == POLL_LAST);
    // A request arriving this cycle already outranks a poll falling due now.
    want_write  = skip_pend | skip_req;
    xfer_done   = (state == ACCESS) && apb.PREADY;
    xfer_abort  = (state == ACCESS) && !apb.PREADY && (acc_cnt == TIMEOUT_LAST);
    case (state)
      IDLE: begin
        if (want_write) begin
          state_n     = SETUP;
          cur_write_n = 1'b1;
          if (!poll_due) poll_cnt_n = poll_cnt + 8'd1;
        end else if (poll_due) begin
          state_n     = SETUP;
          cur_write_n = 1'b0;
          poll_cnt_n  = 8'd0;
        end else begin
          poll_cnt_n = poll_cnt + 8'd1;
        end
      end
      SETUP: begin
        state_n   = ACCESS;
        acc_cnt_n = 8'd0;
      end
      ACCESS: begin
        if (xfer_done || xfer_abort) state_n = IDLE;
        else acc_cnt_n = acc_cnt + 8'd1;
      end
      default: state_n = IDLE;
    endcase
    skip_pend_n = skip_req | (skip_pend & ~(xfer_done & cur_write));
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      poll_cnt    <= 8'd0;
      acc_cnt     <= 8'd0;
      skip_pend   <= 1'b0;
      cur_write   <= 1'b0;
      lamp1       <= LAMP_RED;
      lamp2       <= LAMP_RED;
      state_fault <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      poll_cnt    <= poll_cnt_n;
      acc_cnt     <= acc_cnt_n;
      skip_pend   <= skip_pend_n;
      cur_write   <= cur_write_n;
      err_timeout <= xfer_abort;
      if (xfer_done && !cur_write) begin
        lamp1       <= dec1;
        lamp2       <= dec2;
        state_fault <= fault1 | fault2;
      end
    end
  end

  // Bus outputs decode straight from registered state, so reset drops them at once.
  always_comb begin
    apb.PSEL    = (state != IDLE);
    apb.PENABLE = (state == ACCESS);
    apb.PWRITE  = (state != IDLE) && cur_write;
    apb.PADDR   = 32'd0;
    apb.PWDATA  = 32'd0;
    if (state != IDLE) begin
      apb.PADDR  = {28'd0, (cur_write ? CONTROL_REG_ADDR : CURRENT_STATE_ADDR)};
      apb.PWDATA = cur_write ? 32'd1 : 32'd0;
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_svetofor_apb_poller.sv
// Directed bench for the traffic-light APB poller with a two-cycle APB slave model.
module tb_svetofor_apb_poller;
  import svetofor_pkg::*;

  logic        PCLK;
  logic        PRESETn;
  logic        skip_req;
  logic [2:0]  lamp1, lamp2;
  logic        state_fault, err_timeout, busy;
  apb_state_t  fsm_state;

  logic        stall;
  logic [31:0] rdata;
  int          acc_n;
  int          total, bad;
  logic [4:0]  exp_q[$];
  logic [4:0]  obs_q[$];

  svetofor_apb_if apb ();

  svetofor_apb_poller dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(apb), .skip_req(skip_req),
    .lamp1(lamp1), .lamp2(lamp2), .state_fault(state_fault),
    .err_timeout(err_timeout), .busy(busy), .fsm_state(fsm_state)
  );

  // clock / reset
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // slave: PREADY on the second ACCESS cycle unless stalled
  initial begin
    acc_n = 0;
    apb.PREADY = 1'b0;
    apb.PRDATA = 32'd0;
    forever begin
      @(negedge PCLK);
      apb.PRDATA = rdata;
      if (apb.PSEL && apb.PENABLE) begin
        acc_n++;
        if (!stall && acc_n == 2) begin
          apb.PREADY = 1'b1;
          obs_q.push_back({apb.PWRITE, apb.PADDR[3:0]});
        end else begin
          apb.PREADY = 1'b0;
        end
      end else begin
        acc_n = 0;
        apb.PREADY = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input apb_state_t s, input int max, input string tag);
    int n;
    n = 0;
    while (fsm_state != s && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(fsm_state), 32'(s));
  endtask

  task automatic run_xfer(input logic w, input string tag);
    wait_state(SETUP, 40, {tag, "_wait"});
    chk({tag, "_setup_psel"}, 32'(apb.PSEL), 32'd1);
    chk({tag, "_setup_pen"}, 32'(apb.PENABLE), 32'd0);
    chk({tag, "_pwrite"}, 32'(apb.PWRITE), 32'(w));
    chk({tag, "_paddr"}, apb.PADDR, w ? 32'h0 : 32'h4);
    chk({tag, "_pwdata"}, apb.PWDATA, w ? 32'd1 : 32'd0);
    tick();
    chk({tag, "_acc1"}, 32'(fsm_state), 32'(ACCESS));
    chk({tag, "_acc_pen"}, 32'(apb.PENABLE), 32'd1);
    chk({tag, "_acc_paddr"}, apb.PADDR, w ? 32'h0 : 32'h4);
    tick();
    chk({tag, "_acc2"}, 32'(fsm_state), 32'(ACCESS));
    tick();
    chk({tag, "_done_idle"}, 32'(fsm_state), 32'(IDLE));
    chk({tag, "_done_psel"}, 32'(apb.PSEL), 32'd0);
    exp_q.push_back({w, (w ? 4'h0 : 4'h4)});
  endtask

  initial begin
    total = 0;
    bad = 0;
    PRESETn = 1'b0;
    skip_req = 1'b0;
    stall = 1'b0;
    rdata = 32'hABCD_1238;

    // reset state
    tick(); tick();
    chk("rst_psel", 32'(apb.PSEL), 32'd0);
    chk("rst_penable", 32'(apb.PENABLE), 32'd0);
    chk("rst_pwrite", 32'(apb.PWRITE), 32'd0);
    chk("rst_paddr", apb.PADDR, 32'd0);
    chk("rst_pwdata", apb.PWDATA, 32'd0);
    chk("rst_lamp1", 32'(lamp1), 32'(3'b100));
    chk("rst_lamp2", 32'(lamp2), 32'(3'b100));
    chk("rst_fault", 32'(state_fault), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // idle polling: eight IDLE cycles, then a read of 0x4
    repeat (7) tick();
    chk("poll1_still_idle", 32'(fsm_state), 32'(IDLE));
    tick();
    chk("poll1_setup", 32'(fsm_state), 32'(SETUP));
    chk("poll1_busy", 32'(busy), 32'd1);
    run_xfer(1'b0, "poll1");
    chk("poll1_lamp1", 32'(lamp1), 32'(3'b001));
    chk("poll1_lamp2", 32'(lamp2), 32'(3'b100));
    repeat (7) tick();
    chk("poll2_still_idle", 32'(busy), 32'd0);
    tick();
    chk("poll2_setup", 32'(fsm_state), 32'(SETUP));
    run_xfer(1'b0, "poll2");

    // single skip request
    tick(); tick();
    skip_req = 1'b1;
    tick();
    skip_req = 1'b0;
    run_xfer(1'b1, "skip1");
    run_xfer(1'b0, "skip1_next_read");

    // three pulses while pending coalesce into one write
    skip_req = 1'b1;
    tick();
    chk("coal_setup_write", 32'(apb.PWRITE), 32'd1);
    tick();
    tick();
    skip_req = 1'b0;
    tick();
    chk("coal_done_idle", 32'(fsm_state), 32'(IDLE));
    exp_q.push_back(5'b1_0000);
    run_xfer(1'b0, "coal_next_read");

    // skip request in the cycle the poll falls due
    repeat (7) tick();
    chk("prio_idle_due", 32'(fsm_state), 32'(IDLE));
    skip_req = 1'b1;
    tick();
    skip_req = 1'b0;
    run_xfer(1'b1, "prio_write");
    tick();
    chk("prio_read_after_one_idle", 32'(fsm_state), 32'(SETUP));
    run_xfer(1'b0, "prio_read");

    // fault code and its clearing
    rdata = 32'h0000_000D;
    run_xfer(1'b0, "fault_read");
    chk("fault_lamp1", 32'(lamp1), 32'(3'b100));
    chk("fault_lamp2", 32'(lamp2), 32'(3'b010));
    chk("fault_set", 32'(state_fault), 32'd1);
    rdata = 32'h0000_0002;
    run_xfer(1'b0, "clear_read");
    chk("clear_lamp1", 32'(lamp1), 32'(3'b100));
    chk("clear_lamp2", 32'(lamp2), 32'(3'b001));
    chk("clear_fault", 32'(state_fault), 32'd0);

    // read timeout: lamps stay put
    stall = 1'b1;
    rdata = 32'h0000_0005;
    wait_state(SETUP, 40, "tmo_rd_wait");
    chk("tmo_rd_pwrite", 32'(apb.PWRITE), 32'd0);
    tick();
    repeat (15) tick();
    chk("tmo_rd_acc16", 32'(fsm_state), 32'(ACCESS));
    chk("tmo_rd_err_early", 32'(err_timeout), 32'd0);
    tick();
    chk("tmo_rd_idle", 32'(fsm_state), 32'(IDLE));
    chk("tmo_rd_err", 32'(err_timeout), 32'd1);
    chk("tmo_rd_cycles", 32'(acc_n), 32'd16);
    chk("tmo_rd_lamp1", 32'(lamp1), 32'(3'b100));
    chk("tmo_rd_lamp2", 32'(lamp2), 32'(3'b001));
    tick();
    chk("tmo_rd_err_pulse", 32'(err_timeout), 32'd0);

    // write timeout: write re-issued
    skip_req = 1'b1;
    tick();
    skip_req = 1'b0;
    chk("tmo_wr_setup", 32'(apb.PWRITE), 32'd1);
    tick();
    repeat (15) tick();
    tick();
    chk("tmo_wr_idle", 32'(fsm_state), 32'(IDLE));
    chk("tmo_wr_err", 32'(err_timeout), 32'd1);
    stall = 1'b0;
    tick();
    chk("tmo_wr_retry_setup", 32'(fsm_state), 32'(SETUP));
    chk("tmo_wr_err_pulse", 32'(err_timeout), 32'd0);
    run_xfer(1'b1, "retry_write");
    run_xfer(1'b0, "retry_read");
    chk("retry_lamp1", 32'(lamp1), 32'(3'b010));
    chk("retry_lamp2", 32'(lamp2), 32'(3'b010));

    // reset during ACCESS
    skip_req = 1'b1;
    tick();
    skip_req = 1'b0;
    tick();
    chk("mid_rst_in_access", 32'(fsm_state), 32'(ACCESS));
    #2;
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(apb.PSEL), 32'd0);
    chk("mid_rst_penable", 32'(apb.PENABLE), 32'd0);
    chk("mid_rst_lamp1", 32'(lamp1), 32'(3'b100));
    chk("mid_rst_lamp2", 32'(lamp2), 32'(3'b100));
    chk("mid_rst_flags", 32'({state_fault, err_timeout, busy}), 32'd0);
    tick(); tick();
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (7) tick();
    chk("post_rst_idle", 32'(fsm_state), 32'(IDLE));
    tick();
    chk("post_rst_read_not_write", 32'(apb.PWRITE), 32'd0);
    run_xfer(1'b0, "post_rst_read");

    // completed-transfer log against the expected queue
    chk("log_size", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("log_%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
